// File: rtl/sram_arbiter_pkg.sv
// Shared datapath sizing and arbiter-wide constants.
package sram_arbiter_pkg;

    // Datapath-wide defaults: SRAM word width and log2 of the largest T buffer.
    localparam int Sram_Word      = 64;
    localparam int Max_T_size_log = 10;

    // Requester indices into the per-port pointer arrays.
    localparam int NUM_PORTS = 2;
    localparam int RD_IDX    = 0;
    localparam int WR_IDX    = 1;

endpackage

// File: rtl/sram_arbiter_wrap_ptr.sv
// Address counter that wraps at t_size-1 and toggles a pass (phase) bit on wrap.
module wrap_ptr #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] t_size,
    output logic [ADDR_W-1:0] ptr,
    output logic              phase
);

    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;
    logic              phase_reg;
    logic              phase_next;
    logic              at_end;

    // Next pointer/phase: clear at run start, step or wrap on each grant.
    always_comb begin
        at_end     = (ptr_reg == ADDR_W'(t_size - 1'b1));
        ptr_next   = ptr_reg;
        phase_next = phase_reg;
        if (clear) begin
            ptr_next   = '0;
            phase_next = 1'b0;
        end else if (advance) begin
            if (at_end) begin
                ptr_next   = '0;
                phase_next = ~phase_reg;
            end else begin
                ptr_next = ptr_reg + 1'b1;
            end
        end
    end

    // Pointer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            phase_reg <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            phase_reg <= phase_next;
        end
    end

    assign ptr   = ptr_reg;
    assign phase = phase_reg;

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between a T-buffer reader and its write-back path.
// The reader may run at most one pass ahead of write-back, and write-back may
// never overtake reading; both are tracked by a pointer plus a pass bit.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WORD_W = Sram_Word,
    parameter int ADDR_W = Max_T_size_log
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_t_size,
    input  logic              i_rd_req,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_rd_last,
    input  logic              i_wr_req,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic              o_wr_gnt,
    output logic              o_cen,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_addr,
    output logic [WORD_W-1:0] o_wdata,
    input  logic [WORD_W-1:0] i_rdata,
    output logic              o_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] t_size_reg;
    logic              rr_last_wr_reg;   // 1 = most recent grant went to the writer
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic              busy_reg;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] ptr;
    logic [NUM_PORTS-1:0]             phase;
    logic [NUM_PORTS-1:0]             adv;

    logic run_load;
    logic grant_ok;
    logic rd_elig;
    logic wr_elig;
    logic rd_gnt;
    logic wr_gnt;

    assign run_load = !rst && (state_reg == ST_IDLE) && i_start && (i_t_size != '0);
    assign grant_ok = !rst && (state_reg == ST_RUN) && !i_stop;

    // One wrapping pointer per requester: index 0 reads, index 1 writes back.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ptr
            wrap_ptr #(
                .ADDR_W (ADDR_W)
            ) u_wrap_ptr (
                .clk     (clk),
                .rst     (rst),
                .clear   (run_load),
                .advance (adv[gi]),
                .t_size  (t_size_reg),
                .ptr     (ptr[gi]),
                .phase   (phase[gi])
            );
        end
    endgenerate

    // Eligibility and round-robin grant selection, at most one grant per cycle.
    always_comb begin
        rd_elig = i_rd_req && ((phase[RD_IDX] == phase[WR_IDX]) || (ptr[RD_IDX] < ptr[WR_IDX]));
        wr_elig = i_wr_req && ((phase[RD_IDX] != phase[WR_IDX]) || (ptr[WR_IDX] < ptr[RD_IDX]));
        rd_gnt  = 1'b0;
        wr_gnt  = 1'b0;
        if (grant_ok) begin
            if (rd_elig && wr_elig) begin
                rd_gnt = rr_last_wr_reg;
                wr_gnt = !rr_last_wr_reg;
            end else begin
                rd_gnt = rd_elig;
                wr_gnt = wr_elig;
            end
        end
        adv[RD_IDX] = rd_gnt;
        adv[WR_IDX] = wr_gnt;
    end

    // SRAM port drive for the granted access; all zero when nothing is granted.
    always_comb begin
        o_rd_gnt = rd_gnt;
        o_wr_gnt = wr_gnt;
        o_cen    = rd_gnt || wr_gnt;
        o_wen    = wr_gnt;
        o_addr   = '0;
        o_wdata  = '0;
        if (wr_gnt) begin
            o_addr  = ptr[WR_IDX];
            o_wdata = i_wr_data;
        end else if (rd_gnt) begin
            o_addr = ptr[RD_IDX];
        end
    end

    // Run control, round-robin history and the registered read response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            t_size_reg     <= '0;
            rr_last_wr_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            rd_valid_reg <= rd_gnt;
            rd_last_reg  <= rd_gnt && (ptr[RD_IDX] == ADDR_W'(t_size_reg - 1'b1));
            if (rd_gnt || wr_gnt) begin
                rr_last_wr_reg <= wr_gnt;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (run_load) begin
                        state_reg  <= ST_RUN;
                        t_size_reg <= i_t_size;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_valid = rd_valid_reg;
    assign o_rd_last  = rd_last_reg;
    assign o_rd_data  = (rd_valid_reg && !rst) ? i_rdata : '0;
    assign o_busy     = busy_reg;

endmodule
